// File: rtl/epp_pkg.sv
// Shared encodings and default timing for the DEPP host-side master.
package epp_pkg;

    localparam logic [1:0] EPP_OP_AW = 2'b00;
    localparam logic [1:0] EPP_OP_DW = 2'b01;
    localparam logic [1:0] EPP_OP_DR = 2'b10;
    localparam logic [1:0] EPP_OP_AR = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int EPP_SYNC_STAGES = 2;
    localparam int EPP_SETUP_CYC   = 2;
    localparam int EPP_TIMEOUT_CYC = 1024;

    // Address cycles are the two ops whose bits agree (AW=00, AR=11).
    function automatic logic is_addr_op(input logic [1:0] op);
        return op[0] == op[1];
    endfunction

endpackage

// File: rtl/epp_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module epp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/epp_host_master.sv
// DEPP initiator: turns one byte command into one complete strobe/wait bus cycle
// and reports read data or an abort through a single-cycle response pulse.
module epp_host_master
    import epp_pkg::*;
#(
    parameter int SYNC_STAGES = EPP_SYNC_STAGES,
    parameter int SETUP_CYC   = EPP_SETUP_CYC,
    parameter int TIMEOUT_CYC = EPP_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    // Command: a transfer happens on a rising edge where cmd_valid & cmd_ready;
    // cmd_op/cmd_wdata are sampled only then, cmd_valid may stay high while busy.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       epp_astrb,
    output logic       epp_dstrb,
    output logic       epp_rnw,
    output logic [7:0] epp_dout,
    output logic       epp_oe,
    input  logic [7:0] epp_din,
    input  logic       epp_wait,
    output logic [2:0] fsm_state
);

    // One counter serves both the setup delay and the wait-edge timeout.
    localparam int CNT_TOP = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MIN_LAST   = CW'(SYNC_STAGES);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [7:0]    rdata_q;
    logic          to_q;
    logic          ready_en;
    logic          wait_s;

    epp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_wait_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (epp_wait),
        .q     (wait_s)
    );

    // ready_en keeps cmd_ready low until the first clock after reset release.
    assign cmd_ready = ready_en && (state == ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_q        <= EPP_OP_AW;
            rdata_q     <= '0;
            to_q        <= 1'b0;
            ready_en    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            epp_astrb   <= 1'b1;
            epp_dstrb   <= 1'b1;
            epp_rnw     <= 1'b1;
            epp_oe      <= 1'b0;
            epp_dout    <= '0;
        end else begin
            ready_en  <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q     <= cmd_op;
                        epp_rnw  <= cmd_op[1];
                        epp_oe   <= ~cmd_op[1];
                        epp_dout <= cmd_wdata;
                        rdata_q  <= '0;
                        to_q     <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= ST_STROBE;
                        if (is_addr_op(op_q)) begin
                            epp_astrb <= 1'b0;
                        end else begin
                            epp_dstrb <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Holding off until MIN_LAST guarantees the target sees the strobe
                // low for at least SYNC_STAGES+1 clocks, even with wait stuck high.
                ST_STROBE: begin
                    if (wait_s && (cnt >= MIN_LAST)) begin
                        if (op_q[1]) begin
                            rdata_q <= epp_din;
                        end
                        epp_astrb <= 1'b1;
                        epp_dstrb <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RELEASE;
                    end else if (cnt == TO_LAST) begin
                        epp_astrb <= 1'b1;
                        epp_dstrb <= 1'b1;
                        to_q      <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!wait_s) begin
                        cnt         <= '0;
                        state       <= ST_DONE;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= to_q;
                        rsp_rdata   <= to_q ? 8'h00 : rdata_q;
                    end else if (cnt == TO_LAST) begin
                        to_q        <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DONE;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 8'h00;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    epp_oe  <= 1'b0;
                    epp_rnw <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
